vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE, default 25: item price in cents, a multiple of 5 in the range 5..95.
REQ-002 SHALL have parameter MAX_CREDIT, default 95: maximum credit in cents, a multiple of 5 and >= PRICE.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: inactivity limit, used only with VEND_TIMEOUT_EN.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port Quarters, input, 1 bit: one-cycle pulse, 25c coin inserted.
REQ-007 SHALL have port Dimes, input, 1 bit: one-cycle pulse, 10c coin inserted.
REQ-008 SHALL have port Nickles, input, 1 bit: one-cycle pulse, 5c coin inserted.
REQ-009 SHALL have port Buy, input, 1 bit: purchase request, sampled each cycle.
REQ-010 SHALL have port Refund, input, 1 bit: return-credit request, sampled each cycle.
REQ-011 SHALL have port DispenseDone, input, 1 bit: dispenser acknowledge.
REQ-012 SHALL have port Credit, output, 7 bits: current credit in cents, registered.
REQ-013 SHALL have port Vending, output, 1 bit: high throughout the DISPENSE state.
REQ-014 SHALL have port CoinOut, output, 2 bits: 00 none, 01 nickel, 10 dime, 11 quarter; at most one coin per cycle.
REQ-015 SHALL have port Reject, output, 1 bit: one-cycle pulse when any inserted coin is not accepted.
REQ-016 SHALL have port Busy, output, 1 bit: high in the DISPENSE and CHANGE states.

Function
REQ-017 SHALL implement states IDLE, CREDIT, DISPENSE and CHANGE; all outputs SHALL be registered.
REQ-018 Coin acceptance SHALL be permitted only in IDLE and CREDIT.
- At most one coin is accepted per cycle, priority Quarters > Dimes > Nickles.
- Every other coin asserted in that cycle SHALL assert Reject on the next cycle.
REQ-019 A coin SHALL be rejected, and Credit left unchanged, in any of these cases:
- Credit + coin value > MAX_CREDIT;
- the state is DISPENSE or CHANGE;
- Buy or Refund is taken in the same cycle.
REQ-020 An accepted coin SHALL update Credit one cycle after its pulse; IDLE -> CREDIT on the first accepted coin.
REQ-021 In CREDIT, Buy with Credit >= PRICE SHALL enter DISPENSE next cycle with Credit reduced by PRICE in the same edge; Buy with Credit < PRICE SHALL be ignored.
REQ-022 In CREDIT, Refund SHALL enter CHANGE; Buy and Refund together SHALL take Buy if affordable, else Refund.
REQ-023 Refund in IDLE SHALL be ignored; Buy/Refund in DISPENSE/CHANGE SHALL be ignored.
REQ-024 DISPENSE SHALL hold Vending=1 until DispenseDone, then go to CHANGE if Credit != 0, else to IDLE; DispenseDone outside DISPENSE SHALL be ignored.
REQ-025 CHANGE SHALL, each cycle, output the largest coin <= Credit and subtract its value; when Credit reaches 0 it SHALL go to IDLE with CoinOut=00 on the following cycle.
REQ-026 Credit arithmetic SHALL be 7-bit unsigned and SHALL never underflow or exceed MAX_CREDIT.

Reset
REQ-027 Reset SHALL, at the next rising edge, force state IDLE and Credit=0, with Vending, CoinOut, Reject, Busy and the timeout counter all 0.
REQ-028 Reset SHALL override all inputs and SHALL discard credit mid-DISPENSE or mid-CHANGE, with no coins returned.

Configuration
REQ-029 With VEND_TIMEOUT_EN defined, an 8-bit counter SHALL run in CREDIT.
- It clears on any accepted coin and on entry to CREDIT.
- On reaching TIMEOUT_CYCLES it SHALL force CHANGE.
REQ-030 Without VEND_TIMEOUT_EN, no counter SHALL exist and CREDIT SHALL persist indefinitely.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum, the CoinOut encoding enum, and coin value constants 25/10/5.
REQ-032 Sub-module change_picker SHALL be combinational (Credit in, coin code and value out) and SHALL be used by CHANGE.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Q, Buy -> Vending=1 until DispenseDone, then IDLE, Credit=0, no change.
- Q, Q, D, Buy, DispenseDone -> CoinOut 11, 10, then IDLE; Credit 60 -> 35 -> 10 -> 0.
- D, N, Refund -> CoinOut 10, 01 on consecutive cycles, then 00.
- Credit 90, Dimes -> Reject=1, Credit stays 90; Q and D in the same cycle from 0 -> Credit 25, Reject=1.
- Buy at Credit 20 -> ignored; Reset during CHANGE at Credit 35 -> Credit 0, CoinOut 00, IDLE next cycle.
- With VEND_TIMEOUT_EN: N, then 255 idle cycles -> CoinOut 01, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: controller states,
// the CoinOut encoding and the value in cents of each accepted coin.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_e;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_e;

   localparam logic [6:0] VAL_QUARTER = 7'd25;
   localparam logic [6:0] VAL_DIME    = 7'd10;
   localparam logic [6:0] VAL_NICKEL  = 7'd5;

endpackage

// File: rtl/change_picker.sv
// Combinational change selector: the largest coin not exceeding the remaining
// credit, with its value, so CHANGE can pay out greedily one coin per cycle.
module change_picker
   import vend_pkg::*;
(
   input  logic [6:0] credit,
   output coin_e      coin,
   output logic [6:0] value
);

   // Largest coin that still fits in the remaining credit.
   always_comb begin
      coin  = COIN_NONE;
      value = '0;
      if (credit >= VAL_QUARTER) begin
         coin  = COIN_QUARTER;
         value = VAL_QUARTER;
      end else if (credit >= VAL_DIME) begin
         coin  = COIN_DIME;
         value = VAL_DIME;
      end else if (credit >= VAL_NICKEL) begin
         coin  = COIN_NICKEL;
         value = VAL_NICKEL;
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accepts coins, sells one item at PRICE, and pays
// back any remaining credit one coin per cycle. All outputs are registered.
// Optional build macro VEND_TIMEOUT_EN adds an inactivity timeout in CREDIT
// that forces a refund after TIMEOUT_CYCLES quiet cycles.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no credit, waiting for the first coin
// ST_CREDIT   | credit held, coins / Buy / Refund accepted
// ST_DISPENSE | item being dispensed, waiting for DispenseDone
// ST_CHANGE   | paying out remaining credit, one coin per cycle
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE          = 25,
   parameter int MAX_CREDIT     = 95,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Quarters,
   input  logic       Dimes,
   input  logic       Nickles,
   input  logic       Buy,
   input  logic       Refund,
   input  logic       DispenseDone,
   output logic [6:0] Credit,
   output logic       Vending,
   output logic [1:0] CoinOut,
   output logic       Reject,
   output logic       Busy
);

   localparam logic [7:0] PRICE_W = 8'(PRICE);
   localparam logic [7:0] MAX_W   = 8'(MAX_CREDIT);

   vend_state_e state_q, state_d;
   logic [6:0]  credit_q, credit_d;
   coin_e       coinout_q, coin_d;
   logic        vending_q, busy_q, reject_q, reject_d;

   logic [6:0]  coin_val;
   logic [1:0]  coin_cnt;
   logic        coin_any;
   logic [7:0]  coin_sum;
   logic        buy_ok, refund_ok, coin_ok;

   coin_e       pick_coin;
   logic [6:0]  pick_val;

`ifdef VEND_TIMEOUT_EN
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);
   logic [7:0] tmo_q;
   logic       tmo_expired;
   assign tmo_expired = (state_q == ST_CREDIT) && (tmo_q == 8'd0);
`else
   // The limit has no effect when the timeout is not built in.
   logic [7:0] unused_timeout_limit;
   assign unused_timeout_limit = 8'(TIMEOUT_CYCLES);
`endif

   change_picker u_change_picker (
      .credit (credit_q),
      .coin   (pick_coin),
      .value  (pick_val)
   );

   // Coin candidate (Q > D > N) and the acceptance / transaction decisions.
   always_comb begin
      coin_val = '0;
      if (Quarters)     coin_val = VAL_QUARTER;
      else if (Dimes)   coin_val = VAL_DIME;
      else if (Nickles) coin_val = VAL_NICKEL;
      coin_any  = Quarters | Dimes | Nickles;
      coin_cnt  = {1'b0, Quarters} + {1'b0, Dimes} + {1'b0, Nickles};
      coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
      buy_ok    = (state_q == ST_CREDIT) && Buy && ({1'b0, credit_q} >= PRICE_W);
      // A refund only wins when Buy is not affordable in the same cycle.
      refund_ok = (state_q == ST_CREDIT) && Refund && !buy_ok;
      coin_ok   = coin_any && !buy_ok && !refund_ok && (coin_sum <= MAX_W) &&
                  ((state_q == ST_IDLE) || (state_q == ST_CREDIT));
      // Every asserted coin that was not the accepted one is rejected.
      reject_d  = coin_ok ? (coin_cnt > 2'd1) : coin_any;
   end

   // Next-state, credit and change-coin selection.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      coin_d   = COIN_NONE;
      case (state_q)
         ST_IDLE: begin
            if (coin_ok) begin
               credit_d = coin_sum[6:0];
               state_d  = ST_CREDIT;
            end
         end
         ST_CREDIT: begin
            if (buy_ok) begin
               credit_d = credit_q - PRICE_W[6:0];
               state_d  = ST_DISPENSE;
            end else if (refund_ok) begin
               state_d  = ST_CHANGE;
            end else if (coin_ok) begin
               credit_d = coin_sum[6:0];
`ifdef VEND_TIMEOUT_EN
            end else if (tmo_expired) begin
               state_d  = ST_CHANGE;
`endif
            end
         end
         ST_DISPENSE: begin
            if (DispenseDone) state_d = (credit_q != 7'd0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            // The coin goes out on the same edge its value leaves Credit;
            // an empty credit spends one more cycle here with CoinOut idle.
            if (credit_q != 7'd0) begin
               credit_d = credit_q - pick_val;
               coin_d   = pick_coin;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, credit and registered outputs; Reset discards credit silently.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         credit_q  <= '0;
         coinout_q <= COIN_NONE;
         vending_q <= 1'b0;
         busy_q    <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         coinout_q <= coin_d;
         vending_q <= (state_d == ST_DISPENSE);
         busy_q    <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
         reject_q  <= reject_d;
      end
   end

`ifdef VEND_TIMEOUT_EN
   // Inactivity down-counter: reloads on CREDIT entry or an accepted coin,
   // expires at zero.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tmo_q <= '0;
      end else if ((state_d == ST_CREDIT) && ((state_q != ST_CREDIT) || coin_ok)) begin
         tmo_q <= TMO_LOAD;
      end else if (state_d != ST_CREDIT) begin
         tmo_q <= '0;
      end else if (tmo_q != 8'd0) begin
         tmo_q <= tmo_q - 8'd1;
      end
   end
`endif

   assign Credit  = credit_q;
   assign Vending = vending_q;
   assign CoinOut = coinout_q;
   assign Reject  = reject_q;
   assign Busy    = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus a randomized run checked
// against a coin-level reference model.
module tb_vend_sequencer;

   localparam int PRICE = 25;
   localparam int MAXC  = 95;

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_Q    = 6'b100000;
   localparam logic [5:0] C_D    = 6'b010000;
   localparam logic [5:0] C_N    = 6'b001000;
   localparam logic [5:0] C_BUY  = 6'b000100;
   localparam logic [5:0] C_REF  = 6'b000010;
   localparam logic [5:0] C_DONE = 6'b000001;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       Quarters = 1'b0, Dimes = 1'b0, Nickles = 1'b0;
   logic       Buy = 1'b0, Refund = 1'b0, DispenseDone = 1'b0;
   logic [6:0] Credit;
   logic       Vending, Reject, Busy;
   logic [1:0] CoinOut;

   int checks   = 0;
   int failures = 0;

   vend_sequencer #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(255)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Quarters     (Quarters),
      .Dimes        (Dimes),
      .Nickles      (Nickles),
      .Buy          (Buy),
      .Refund       (Refund),
      .DispenseDone (DispenseDone),
      .Credit       (Credit),
      .Vending      (Vending),
      .CoinOut      (CoinOut),
      .Reject       (Reject),
      .Busy         (Busy)
   );

   always #5 Clock = ~Clock;

   // Drive one cycle of inputs {Q,D,N,Buy,Refund,Done}, sample 1ns after the edge.
   task automatic cycle(input logic [5:0] v);
      {Quarters, Dimes, Nickles, Buy, Refund, DispenseDone} = v;
      @(posedge Clock);
      #1;
      {Quarters, Dimes, Nickles, Buy, Refund, DispenseDone} = C_IDLE;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cycle(C_IDLE);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      cycle(C_Q | C_DONE | C_BUY);
      Reset = 1'b0;
      checks++; if (Credit !== 7'd0)   begin failures++; $display("FAIL rst_credit got=%0d exp=0", Credit); end
      checks++; if (Vending !== 1'b0)  begin failures++; $display("FAIL rst_vending got=%b exp=0", Vending); end
      checks++; if (CoinOut !== 2'b00) begin failures++; $display("FAIL rst_coinout got=%b exp=00", CoinOut); end
      checks++; if (Reject !== 1'b0)   begin failures++; $display("FAIL rst_reject got=%b exp=0", Reject); end
      checks++; if (Busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
   endtask

   task automatic test_buy_exact();
      do_reset();
      cycle(C_Q);
      checks++; if (Credit !== 7'd25) begin failures++; $display("FAIL buy_q_credit got=%0d exp=25", Credit); end
      cycle(C_BUY);
      checks++; if (Vending !== 1'b1 || Busy !== 1'b1) begin failures++; $display("FAIL buy_vending got=%b/%b exp=1/1", Vending, Busy); end
      checks++; if (Credit !== 7'd0) begin failures++; $display("FAIL buy_credit got=%0d exp=0", Credit); end
      cycle(C_N);
      checks++; if (Reject !== 1'b1 || Credit !== 7'd0) begin failures++; $display("FAIL disp_coin_reject got=%b/%0d exp=1/0", Reject, Credit); end
      cycle(C_IDLE);
      checks++; if (Vending !== 1'b1) begin failures++; $display("FAIL buy_vending_hold got=%b exp=1", Vending); end
      cycle(C_DONE);
      checks++; if (Vending !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL buy_done got=%b/%b exp=0/0", Vending, Busy); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b00 || Credit !== 7'd0) begin failures++; $display("FAIL buy_nochange got=%b/%0d exp=00/0", CoinOut, Credit); end
   endtask

   task automatic test_change();
      int k;
      do_reset();
      cycle(C_Q); cycle(C_Q); cycle(C_D);
      checks++; if (Credit !== 7'd60) begin failures++; $display("FAIL chg_credit60 got=%0d exp=60", Credit); end
      cycle(C_BUY);
      checks++; if (Credit !== 7'd35) begin failures++; $display("FAIL chg_credit35 got=%0d exp=35", Credit); end
      cycle(C_DONE);
      k = 0;
      while (CoinOut == 2'b00 && k < 8) begin cycle(C_IDLE); k++; end
      checks++; if (CoinOut !== 2'b11 || Credit !== 7'd10) begin failures++; $display("FAIL chg_quarter got=%b/%0d exp=11/10", CoinOut, Credit); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b10 || Credit !== 7'd0) begin failures++; $display("FAIL chg_dime got=%b/%0d exp=10/0", CoinOut, Credit); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b00 || Busy !== 1'b0) begin failures++; $display("FAIL chg_end got=%b/%b exp=00/0", CoinOut, Busy); end
   endtask

   task automatic test_refund();
      int k;
      do_reset();
      cycle(C_D); cycle(C_N);
      checks++; if (Credit !== 7'd15) begin failures++; $display("FAIL ref_credit got=%0d exp=15", Credit); end
      cycle(C_REF);
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL ref_busy got=%b exp=1", Busy); end
      k = 0;
      while (CoinOut == 2'b00 && k < 8) begin cycle(C_IDLE); k++; end
      checks++; if (CoinOut !== 2'b10 || Credit !== 7'd5) begin failures++; $display("FAIL ref_dime got=%b/%0d exp=10/5", CoinOut, Credit); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b01 || Credit !== 7'd0) begin failures++; $display("FAIL ref_nickel got=%b/%0d exp=01/0", CoinOut, Credit); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b00) begin failures++; $display("FAIL ref_end got=%b exp=00", CoinOut); end
   endtask

   task automatic test_reject();
      do_reset();
      cycle(C_Q); cycle(C_Q); cycle(C_Q); cycle(C_D); cycle(C_N);
      checks++; if (Credit !== 7'd90) begin failures++; $display("FAIL rej_credit90 got=%0d exp=90", Credit); end
      cycle(C_D);
      checks++; if (Reject !== 1'b1 || Credit !== 7'd90) begin failures++; $display("FAIL rej_over got=%b/%0d exp=1/90", Reject, Credit); end
      cycle(C_N);
      checks++; if (Reject !== 1'b0 || Credit !== 7'd95) begin failures++; $display("FAIL rej_at_max got=%b/%0d exp=0/95", Reject, Credit); end
      cycle(C_N);
      checks++; if (Reject !== 1'b1 || Credit !== 7'd95) begin failures++; $display("FAIL rej_full got=%b/%0d exp=1/95", Reject, Credit); end
      do_reset();
      cycle(C_Q | C_D);
      checks++; if (Reject !== 1'b1 || Credit !== 7'd25) begin failures++; $display("FAIL rej_two_coins got=%b/%0d exp=1/25", Reject, Credit); end
      cycle(C_IDLE);
      checks++; if (Reject !== 1'b0) begin failures++; $display("FAIL rej_pulse got=%b exp=0", Reject); end
   endtask

   task automatic test_buy_low_and_reset_change();
      do_reset();
      cycle(C_D); cycle(C_D);
      cycle(C_BUY);
      checks++; if (Credit !== 7'd20 || Busy !== 1'b0 || Vending !== 1'b0) begin failures++; $display("FAIL low_buy got=%0d/%b/%b exp=20/0/0", Credit, Busy, Vending); end
      do_reset();
      cycle(C_Q); cycle(C_D);
      cycle(C_REF);
      checks++; if (Credit !== 7'd35 || Busy !== 1'b1) begin failures++; $display("FAIL rc_change got=%0d/%b exp=35/1", Credit, Busy); end
      do_reset();
      checks++; if (Credit !== 7'd0 || CoinOut !== 2'b00 || Busy !== 1'b0) begin failures++; $display("FAIL rc_reset got=%0d/%b/%b exp=0/00/0", Credit, CoinOut, Busy); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b00 || Busy !== 1'b0) begin failures++; $display("FAIL rc_idle got=%b/%b exp=00/0", CoinOut, Busy); end
   endtask

   task automatic test_timeout();
      int k;
      do_reset();
      cycle(C_N);
`ifdef VEND_TIMEOUT_EN
      k = 0;
      while (CoinOut == 2'b00 && k < 400) begin cycle(C_IDLE); k++; end
      checks++; if (CoinOut !== 2'b01 || k < 255 || k > 260) begin failures++; $display("FAIL tmo_fire got=%b after %0d cycles exp=01 after ~255", CoinOut, k); end
      cycle(C_IDLE);
      checks++; if (CoinOut !== 2'b00 || Busy !== 1'b0 || Credit !== 7'd0) begin failures++; $display("FAIL tmo_idle got=%b/%b/%0d exp=00/0/0", CoinOut, Busy, Credit); end
`else
      k = 0;
      for (int i = 0; i < 300; i++) begin
         cycle(C_IDLE);
         if (CoinOut != 2'b00) k++;
      end
      checks++; if (k != 0 || Credit !== 7'd5 || Busy !== 1'b0) begin failures++; $display("FAIL notmo_hold got=%0d coins/%0d/%b exp=0/5/0", k, Credit, Busy); end
`endif
   endtask

   task automatic test_random();
      int m_mode, m_credit, v, nc, e_coin, c, nfail;
      bit e_rej, tb_, tr_, acc;
      int chg[$];
      logic [5:0] in;
      do_reset();
      m_mode = 0; m_credit = 0; nfail = 0;
      for (int i = 0; i < 3000; i++) begin
         in[5] = ($urandom_range(0, 99) < 15);
         in[4] = ($urandom_range(0, 99) < 15);
         in[3] = ($urandom_range(0, 99) < 15);
         in[2] = ($urandom_range(0, 99) < 12);
         in[1] = ($urandom_range(0, 99) < 6);
         in[0] = ($urandom_range(0, 99) < 30);
         v  = in[5] ? 25 : in[4] ? 10 : in[3] ? 5 : 0;
         nc = int'(in[5]) + int'(in[4]) + int'(in[3]);
         e_coin = 0; e_rej = 0;
         // Mode 0 idle, 1 credit, 2 dispensing, 3 paying out queued change.
         if (m_mode <= 1) begin
            tb_ = (m_mode == 1) && in[2] && (m_credit >= PRICE);
            tr_ = (m_mode == 1) && in[1] && !tb_;
            acc = (nc > 0) && !tb_ && !tr_ && (m_credit + v <= MAXC);
            e_rej = (nc - int'(acc)) > 0;
            if (tb_) begin
               m_credit -= PRICE; m_mode = 2;
            end else if (tr_) begin
               m_mode = 3;
               c = m_credit;
               while (c >= 25) begin chg.push_back(3); c -= 25; end
               while (c >= 10) begin chg.push_back(2); c -= 10; end
               while (c >= 5)  begin chg.push_back(1); c -= 5;  end
            end else if (acc) begin
               m_credit += v; m_mode = 1;
            end
         end else if (m_mode == 2) begin
            e_rej = nc > 0;
            if (in[0]) begin
               if (m_credit > 0) begin
                  m_mode = 3;
                  c = m_credit;
                  while (c >= 25) begin chg.push_back(3); c -= 25; end
                  while (c >= 10) begin chg.push_back(2); c -= 10; end
                  while (c >= 5)  begin chg.push_back(1); c -= 5;  end
               end else m_mode = 0;
            end
         end else begin
            e_rej = nc > 0;
            if (chg.size() > 0) begin
               e_coin = chg.pop_front();
               m_credit -= (e_coin == 3) ? 25 : (e_coin == 2) ? 10 : 5;
            end else m_mode = 0;
         end
         cycle(in);
         checks++; if (Credit !== 7'(m_credit)) begin failures++; nfail++; if (nfail < 10) $display("FAIL rnd_credit cyc=%0d got=%0d exp=%0d", i, Credit, m_credit); end
         checks++; if (Vending !== (m_mode == 2)) begin failures++; nfail++; if (nfail < 10) $display("FAIL rnd_vending cyc=%0d got=%b exp=%b", i, Vending, m_mode == 2); end
         checks++; if (Busy !== (m_mode >= 2)) begin failures++; nfail++; if (nfail < 10) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, Busy, m_mode >= 2); end
         checks++; if (CoinOut !== 2'(e_coin)) begin failures++; nfail++; if (nfail < 10) $display("FAIL rnd_coinout cyc=%0d got=%b exp=%0d", i, CoinOut, e_coin); end
         checks++; if (Reject !== e_rej) begin failures++; nfail++; if (nfail < 10) $display("FAIL rnd_reject cyc=%0d got=%b exp=%b", i, Reject, e_rej); end
      end
   endtask

   initial begin
      test_reset();
      test_buy_exact();
      test_change();
      test_refund();
      test_reject();
      test_buy_low_and_reset_change();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
